// File: rtl/dco_config_sync_ctrl.sv
// DCO-domain receiver for config words sent with a toggle req/ack handshake.
// Synchronizes the request, updates the DCO code, waits out settling, then acks.
module dco_config_sync_ctrl #(
   parameter int                   SyncDepth    = 2,
   parameter int                   DataWidth    = 8,
   parameter int                   SettleCycles = 4,
   parameter logic [DataWidth-1:0] ResetCode    = '0
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 req_toggle,
   input  logic [DataWidth-1:0] req_data,
   input  logic                 clear_overrun,
   output logic [DataWidth-1:0] dco_code,
   output logic                 update_strobe,
   output logic                 ack_toggle,
   output logic                 busy,
   output logic                 overrun
);

   localparam int CW = (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;
   localparam logic [CW-1:0] CntLoad = CW'((SettleCycles > 0) ? SettleCycles - 1 : 0);

   typedef enum logic [1:0] {IDLE, CAPTURE, SETTLE, ACK} state_t;

   state_t                 state_q;
   logic [SyncDepth-1:0]   sync_q;
   logic                   req_seen_q;
   logic [DataWidth-1:0]   dco_q;
   logic                   strobe_q;
   logic                   ack_q;
   logic                   busy_q;
   logic                   ovr_q;
   logic [CW-1:0]          cnt_q;
   logic                   sync_req;
   logic                   pending;

   assign sync_req = sync_q[SyncDepth-1];
   assign pending  = (sync_req != req_seen_q);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         sync_q     <= '0;
         req_seen_q <= 1'b0;
         dco_q      <= ResetCode;
         strobe_q   <= 1'b0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         ovr_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         sync_q   <= {sync_q[SyncDepth-2:0], req_toggle};
         strobe_q <= 1'b0;
         // A new toggle while busy is a protocol violation; setting wins over clearing.
         if (state_q != IDLE && pending)
            ovr_q <= 1'b1;
         else if (clear_overrun)
            ovr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pending) begin
                  req_seen_q <= sync_req;
                  state_q    <= CAPTURE;
                  busy_q     <= 1'b1;
               end
            end
            CAPTURE: begin
               dco_q    <= req_data;
               strobe_q <= 1'b1;
               cnt_q    <= CntLoad;
               state_q  <= (SettleCycles == 0) ? ACK : SETTLE;
            end
            SETTLE: begin
               if (cnt_q == '0)
                  state_q <= ACK;
               else
                  cnt_q <= cnt_q - CW'(1);
            end
            ACK: begin
               ack_q   <= ~ack_q;
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dco_code      = dco_q;
   assign update_strobe = strobe_q;
   assign ack_toggle    = ack_q;
   assign busy          = busy_q;
   assign overrun       = ovr_q;

endmodule

// File: tb/tb_dco_config_sync_ctrl.sv
// Bench for dco_config_sync_ctrl: a default instance (SettleCycles=4) and a
// SettleCycles=0 instance, checked against a per-request timing model.
module tb_dco_config_sync_ctrl;

   localparam int S0 = 4;
   localparam int S1 = 0;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       r0_tog = 1'b0, r1_tog = 1'b0;
   logic [7:0] r0_data = 8'h00, r1_data = 8'h00;
   logic       clr0 = 1'b0, clr1 = 1'b0;
   logic [7:0] dco0, dco1;
   logic       stb0, stb1, ack0, ack1, busy0, busy1, ovr0, ovr1;

   int errs = 0;
   int checks = 0;

   // Model state: last completed code and ack level per instance.
   logic [7:0] exp_code0 = 8'h00, exp_code1 = 8'h00;
   logic       exp_ack0 = 1'b0, exp_ack1 = 1'b0;

   always #5 clock = ~clock;

   dco_config_sync_ctrl #(.SyncDepth(2), .DataWidth(8), .SettleCycles(S0), .ResetCode(8'h00)) dut0 (
      .clock(clock), .reset_n(reset_n), .req_toggle(r0_tog), .req_data(r0_data),
      .clear_overrun(clr0), .dco_code(dco0), .update_strobe(stb0), .ack_toggle(ack0),
      .busy(busy0), .overrun(ovr0));

   dco_config_sync_ctrl #(.SyncDepth(2), .DataWidth(8), .SettleCycles(S1), .ResetCode(8'h00)) dut1 (
      .clock(clock), .reset_n(reset_n), .req_toggle(r1_tog), .req_data(r1_data),
      .clear_overrun(clr1), .dco_code(dco1), .update_strobe(stb1), .ack_toggle(ack1),
      .busy(busy1), .overrun(ovr1));

   // Isolated request toggled in cycle 0 (k = cycles since then): two sync
   // cycles plus detect puts CAPTURE at k=3, the new code at k=4, and the ack
   // flip after s settle cycles and one ACK cycle.
   function automatic logic m_busy(int k, int s);
      return (k >= 3) && (k < s + 5);
   endfunction
   function automatic logic m_stb(int k);
      return k == 4;
   endfunction
   function automatic logic [7:0] m_code(int k, logic [7:0] oldc, logic [7:0] newc);
      return (k >= 4) ? newc : oldc;
   endfunction
   function automatic logic m_ack(int k, int s, logic olda);
      return (k >= s + 5) ? ~olda : olda;
   endfunction

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_reset();
      for (int c = 0; c < 20; c++) begin
         if (c == 10) reset_n = 1'b1;
         step();
         checks++;
         if ({dco0, stb0, ack0, busy0, ovr0} !== 12'h000) begin
            errs++;
            $display("FAIL reset0 c=%0d: got dco=%h stb=%b ack=%b busy=%b ovr=%b want all 0",
                     c, dco0, stb0, ack0, busy0, ovr0);
         end
         checks++;
         if ({dco1, stb1, ack1, busy1, ovr1} !== 12'h000) begin
            errs++;
            $display("FAIL reset1 c=%0d: got dco=%h stb=%b ack=%b busy=%b ovr=%b want all 0",
                     c, dco1, stb1, ack1, busy1, ovr1);
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] oldc = exp_code0;
      logic       olda = exp_ack0;
      r0_data = 8'hA5;
      r0_tog  = ~r0_tog;
      for (int k = 1; k <= S0 + 7; k++) begin
         step();
         checks++;
         if (busy0 !== m_busy(k, S0)) begin
            errs++; $display("FAIL basic_busy k=%0d: got %b want %b", k, busy0, m_busy(k, S0));
         end
         checks++;
         if (stb0 !== m_stb(k)) begin
            errs++; $display("FAIL basic_strobe k=%0d: got %b want %b", k, stb0, m_stb(k));
         end
         checks++;
         if (dco0 !== m_code(k, oldc, 8'hA5)) begin
            errs++; $display("FAIL basic_code k=%0d: got %h want %h", k, dco0, m_code(k, oldc, 8'hA5));
         end
         checks++;
         if (ack0 !== m_ack(k, S0, olda)) begin
            errs++; $display("FAIL basic_ack k=%0d: got %b want %b", k, ack0, m_ack(k, S0, olda));
         end
      end
      exp_code0 = 8'hA5;
      exp_ack0  = ~olda;
   endtask

   task automatic test_settle0();
      logic [7:0] oldc = exp_code1;
      logic       olda = exp_ack1;
      r1_data = 8'h3C;
      r1_tog  = ~r1_tog;
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++;
         if ({busy1, stb1, ack1, dco1} !== {m_busy(k, S1), m_stb(k), m_ack(k, S1, olda), m_code(k, oldc, 8'h3C)}) begin
            errs++;
            $display("FAIL settle0 k=%0d: got busy=%b stb=%b ack=%b dco=%h want busy=%b stb=%b ack=%b dco=%h",
                     k, busy1, stb1, ack1, dco1, m_busy(k, S1), m_stb(k), m_ack(k, S1, olda), m_code(k, oldc, 8'h3C));
         end
      end
      exp_code1 = 8'h3C;
      exp_ack1  = ~olda;
   endtask

   task automatic test_overrun();
      logic olda = exp_ack0;
      clr0 = 1'b1; step(); clr0 = 1'b0;
      checks++;
      if (ovr0 !== 1'b0) begin errs++; $display("FAIL ovr_pre: got %b want 0", ovr0); end
      r0_data = 8'hA5;
      r0_tog  = ~r0_tog;
      for (int k = 1; k <= 18; k++) begin
         step();
         if (k == 2) r0_tog = ~r0_tog;
         if (k == 5) begin
            checks++;
            if (ovr0 !== 1'b1) begin errs++; $display("FAIL ovr_set: got %b want 1", ovr0); end
         end
         if (k == 9) begin
            checks++;
            if ({ack0, busy0} !== {~olda, 1'b0}) begin
               errs++; $display("FAIL ovr_first_ack: got ack=%b busy=%b want ack=%b busy=0", ack0, busy0, ~olda);
            end
            r0_data = 8'h5A;
         end
         if (k == 10) begin
            checks++;
            if (busy0 !== 1'b1) begin errs++; $display("FAIL ovr_recapture: got busy=%b want 1", busy0); end
         end
         if (k == 11) begin
            checks++;
            if ({dco0, stb0} !== {8'h5A, 1'b1}) begin
               errs++; $display("FAIL ovr_code: got dco=%h stb=%b want 5a/1", dco0, stb0);
            end
         end
         if (k == 16) begin
            checks++;
            if ({ack0, busy0, ovr0} !== {olda, 1'b0, 1'b1}) begin
               errs++; $display("FAIL ovr_second_ack: got ack=%b busy=%b ovr=%b want %b/0/1", ack0, busy0, ovr0, olda);
            end
         end
      end
      exp_code0 = 8'h5A;
      exp_ack0  = olda;
   endtask

   task automatic test_clear_overrun();
      logic olda = exp_ack0;
      clr0 = 1'b1; step(); clr0 = 1'b0;
      checks++;
      if (ovr0 !== 1'b0) begin errs++; $display("FAIL clr_plain: got %b want 0", ovr0); end
      r0_data = 8'h11;
      r0_tog  = ~r0_tog;
      for (int k = 1; k <= 18; k++) begin
         step();
         if (k == 2) r0_tog = ~r0_tog;
         if (k == 4) begin
            checks++;
            if (ovr0 !== 1'b0) begin errs++; $display("FAIL clr_before_evt: got %b want 0", ovr0); end
            clr0 = 1'b1;
         end
         if (k == 5) begin
            clr0 = 1'b0;
            checks++;
            if (ovr0 !== 1'b1) begin errs++; $display("FAIL clr_same_cycle: got %b want 1", ovr0); end
         end
      end
      checks++;
      if ({dco0, ack0, busy0} !== {8'h11, olda, 1'b0}) begin
         errs++; $display("FAIL clr_drain: got dco=%h ack=%b busy=%b want 11/%b/0", dco0, ack0, busy0, olda);
      end
      clr0 = 1'b1; step(); clr0 = 1'b0;
      checks++;
      if (ovr0 !== 1'b0) begin errs++; $display("FAIL clr_final: got %b want 0", ovr0); end
      exp_code0 = 8'h11;
      exp_ack0  = olda;
   endtask

   task automatic test_reset_mid();
      r0_data = 8'hA5;
      r0_tog  = ~r0_tog;
      for (int k = 1; k <= 6; k++) step();
      checks++;
      if ({dco0, busy0} !== {8'hA5, 1'b1}) begin
         errs++; $display("FAIL rst_mid_pre: got dco=%h busy=%b want a5/1", dco0, busy0);
      end
      reset_n = 1'b0;
      r0_tog  = 1'b0;
      r1_tog  = 1'b0;
      #1;
      checks++;
      if ({dco0, ack0, busy0, stb0} !== {8'h00, 3'b000}) begin
         errs++; $display("FAIL rst_mid: got dco=%h ack=%b busy=%b stb=%b want 00/0/0/0", dco0, ack0, busy0, stb0);
      end
      exp_code0 = 8'h00; exp_ack0 = 1'b0;
      exp_code1 = 8'h00; exp_ack1 = 1'b0;
      step(); step();
      reset_n = 1'b1;
      step();
      test_basic();
   endtask

   task automatic test_random();
      for (int n = 0; n < 16; n++) begin
         logic [7:0] d    = 8'($urandom);
         logic [7:0] oldc = exp_code0;
         logic       olda = exp_ack0;
         int         idle = $urandom_range(0, 3);
         r0_data = d;
         r0_tog  = ~r0_tog;
         for (int k = 1; k <= S0 + 6 + idle; k++) begin
            step();
            checks++;
            if ({busy0, stb0, ack0, dco0, ovr0} !==
                {m_busy(k, S0), m_stb(k), m_ack(k, S0, olda), m_code(k, oldc, d), 1'b0}) begin
               errs++;
               $display("FAIL rand n=%0d k=%0d: got busy=%b stb=%b ack=%b dco=%h ovr=%b want %b/%b/%b/%h/0",
                        n, k, busy0, stb0, ack0, dco0, ovr0,
                        m_busy(k, S0), m_stb(k), m_ack(k, S0, olda), m_code(k, oldc, d));
            end
         end
         exp_code0 = d;
         exp_ack0  = ~olda;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_settle0();
      test_overrun();
      test_clear_overrun();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
